updown_counter_mod: RTL

Synchronous, parametrised up/down counter: the next-generation replacement for the 4-bit ripple T-flip-flop up/down counter. It adds configurable width and modulus, count enable, parallel load, and wrap or saturate overflow modes, plus terminal-count outputs. It sits in the drill/lab designs wherever a mode-selectable counter or divider is needed. It is fully synchronous, so it has no ripple skew between bits.

---
 rtl/updown_pkg.sv | 25 ++
 rtl/updown_next.sv | 47 ++++
 rtl/updown_counter_mod.sv | 55 +++++
 3 files changed

// File: rtl/updown_pkg.sv
// Shared definitions for the parametrised up/down counter: mode encodings
// and the load clamp helper used by the next-state logic.
package updown_pkg;

  // Direction select values on M
  localparam logic MODE_UP = 1'b0;
  localparam logic MODE_DN = 1'b1;

  // Overflow behaviour values on sat
  localparam logic OVF_WRAP = 1'b0;
  localparam logic OVF_SAT  = 1'b1;

  // Widest internal arithmetic: 16-bit counter plus one guard bit
  localparam int CALC_W = 17;

  // A load value outside the count range is pinned to the top of the range
  function automatic logic [CALC_W-1:0] clamp_load(input logic [CALC_W-1:0] val,
                                                   input logic [CALC_W-1:0] modulus);
    if (val < modulus) begin
      return val;
    end
    return modulus - CALC_W'(1);
  endfunction

endpackage

// File: rtl/updown_next.sv
// Combinational next-state logic for the up/down counter. Works in WIDTH+1
// bits so a non-power-of-two modulus never relies on a natural 2**WIDTH wrap.
module updown_next
  import updown_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic [WIDTH-1:0] q,
  input  logic             m,
  input  logic             sat,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q_next,
  output logic             tc_hit
);

  localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MODULUS - 1);

  logic [WIDTH:0] q_ext;
  logic           at_term;

  assign q_ext   = {1'b0, q};
  assign at_term = (m == MODE_DN) ? (q_ext == '0) : (q_ext == MAX_EXT);

  // Load beats enable; an enabled step from the terminal value wraps or holds and flags tc_hit
  always_comb begin
    q_next = q;
    tc_hit = 1'b0;
    if (load) begin
      q_next = WIDTH'(clamp_load(CALC_W'(load_val), CALC_W'(MODULUS)));
    end else if (en) begin
      if (at_term) begin
        tc_hit = 1'b1;
        if (sat == OVF_WRAP) begin
          q_next = (m == MODE_DN) ? WIDTH'(MAX_EXT) : '0;
        end
      end else if (m == MODE_UP) begin
        q_next = WIDTH'(q_ext + 1'b1);
      end else begin
        q_next = WIDTH'(q_ext - 1'b1);
      end
    end
  end

endmodule

// File: rtl/updown_counter_mod.sv
// Synchronous up/down counter with configurable width and modulus, count
// enable, parallel load, wrap/saturate overflow and terminal-count outputs.
module updown_counter_mod
  import updown_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 16,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             M,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             at_tc,
  output logic             tc_pulse
);

  localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MODULUS - 1);

  logic [WIDTH-1:0] q_next;
  logic             tc_hit;

  updown_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .q        (Q),
    .m        (M),
    .sat      (sat),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .q_next   (q_next),
    .tc_hit   (tc_hit)
  );

  // Terminal value follows M directly so at_tc tracks a direction change without a clock
  assign at_tc = (M == MODE_DN) ? ({1'b0, Q} == '0) : ({1'b0, Q} == MAX_EXT);

  // Count and pulse registers; reset acts immediately, independent of clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Q        <= WIDTH'(RESET_VAL);
      tc_pulse <= 1'b0;
    end else begin
      Q        <= q_next;
      tc_pulse <= tc_hit;
    end
  end

endmodule
